instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the control/decoder: packs CR16a instruction fields into 16-bit words and writes them to program memory.
// - Fields arrive one instruction at a time over a valid/ready handshake.
// - Words are written to consecutive addresses starting at base_addr.
// - Used to load programs into instruction memory before/between CPU runs.
// PARAMETERS
// - ADDR_W      10   program memory address width
// - MAX_INSTRS  256  max words per load session; session ends automatically when reached
// PORTS
// - clk          in   1       system clock
// - reset        in   1       asynchronous, active-low reset
// - start        in   1       one-cycle pulse: begin session (ignored unless IDLE)
// - base_addr    in   ADDR_W  first write address, sampled on start
// - in_valid     in   1       instruction fields valid
// - in_ready     out  1       encoder can accept fields
// - in_last      in   1       final instruction of session (qualified by handshake)
// - use_imm      in   1       1: immediate form, 0: register-register form
// - op           in   4       opcode (ADD=0101, SUB=1001, CMP=1011, ...)
// - rdest        in   4       destination register index
// - rsrc         in   4       source register index (RR form only)
// - imm8         in   8       immediate (immediate form only)
// - mem_we       out  1       memory write strobe
// - mem_addr     out  ADDR_W  memory address
// - mem_wdata    out  16      encoded word
// - mem_rdata    in   16      memory read data, 1-cycle sync read; used only with ENC_READBACK_EN
// - busy         out  1       high in any state other than IDLE
// - done         out  1       one-cycle pulse at end of session
// - err_illegal  out  1       sticky: illegal field combination seen this session
// - err_verify   out  1       sticky: readback mismatch this session (0 without macro)
// - instr_count  out  ADDR_W+1  words written this session
// BEHAVIOUR
// - Encoding:
//   - RR form: {4'b0000, rdest, op, rsrc}.
//   - Immediate form: {op, rdest, imm8}.
//   - Illegal: use_imm=1 with op=0000 (aliases RR space); writes NOP 16'h0000 and sets err_illegal.
// - Reset: state=IDLE; all outputs 0; addr and count registers 0. Reset mid-session aborts; words already written are not undone.
// - FSM states: IDLE, ACCEPT, WRITE, [RDBK, CHECK], DONE.
//   - IDLE: in_ready=0. On start: addr<=base_addr, instr_count<=0, both err flags cleared, go to ACCEPT.
//   - ACCEPT: in_ready=1. On in_valid&&in_ready: register encoded word and in_last, go to WRITE. in_valid=0 holds ACCEPT indefinitely.
//   - WRITE: mem_we=1 for exactly 1 cycle, driving mem_addr=addr and mem_wdata=word. At clock edge: addr<=addr+1 (wraps mod 2^ADDR_W), instr_count<=instr_count+1.
//   - End of session: latched last OR new instr_count==MAX_INSTRS -> DONE; otherwise -> ACCEPT (via RDBK/CHECK when readback is enabled).
//   - DONE: done=1 for one cycle, then -> IDLE. instr_count and err flags hold until next start.
// - Throughput: one instruction per 2 cycles (4 with readback). Latency from handshake to mem_we: 1 cycle.
// - start while busy: ignored.
// - in_valid in IDLE/WRITE/DONE: not accepted; upstream must hold its fields.
// CONFIGURATION
// - ENC_READBACK_EN defined: after WRITE, go to RDBK (mem_we=0, mem_addr=written address), then CHECK.
//   - CHECK: mem_rdata!=word sets err_verify; then end-of-session test as above.
// - Undefined: RDBK/CHECK not built; mem_rdata ignored; err_verify tied 0.
// TESTING
// - start, base=0x010; RR op=0101 rdest=3 rsrc=4 last=1 -> mem_we at addr 0x010 with data 0x0354; done pulse; instr_count=1.
// - Immediate op=0101 rdest=2 imm8=0x7F -> mem_wdata=0x527F; in_ready low during WRITE.
// - use_imm=1 op=0000 -> mem_wdata=0x0000, err_illegal=1 sticky until next start.
// - base=2^ADDR_W-1, 2 instrs -> writes at 0x3FF then 0x000 (wrap); instr_count=2.
// - MAX_INSTRS=4, in_last never asserted -> done after 4th write; start pulse mid-session ignored.
// - Reset asserted during WRITE -> all outputs 0 immediately; IDLE after release.
// - With ENC_READBACK_EN, memory model corrupts a bit -> err_verify=1; clean model -> err_verify=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs CR16a instruction fields into 16-bit words and writes them to consecutive
// program-memory addresses. Optional readback verify is built when ENC_READBACK_EN is defined.
module instr_encoder_loader #(
  parameter int ADDR_W     = 10,
  parameter int MAX_INSTRS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              use_imm,
  input  logic [3:0]        op,
  input  logic [3:0]        rdest,
  input  logic [3:0]        rsrc,
  input  logic [7:0]        imm8,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_verify,
  output logic [ADDR_W:0]   instr_count,
  output logic [2:0]        dbg_state
);

  // Handshake: a field set transfers on a rising clk edge where in_valid && in_ready;
  // in_ready is only high in ACCEPT, so upstream holds its fields in every other state.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_RDBK   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_INSTRS);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              last_q;
  logic [15:0]       enc_word;
  logic              enc_illegal;
  logic [ADDR_W:0]   cnt_inc;

  assign dbg_state = state;
  assign cnt_inc   = instr_count + {{ADDR_W{1'b0}}, 1'b1};

  // An immediate form with a zero opcode would alias the RR space, so it becomes a NOP.
  always_comb begin
    enc_illegal = use_imm && (op == 4'b0000);
    if (enc_illegal)
      enc_word = 16'h0000;
    else if (use_imm)
      enc_word = {op, rdest, imm8};
    else
      enc_word = {4'b0000, rdest, op, rsrc};
  end

`ifdef ENC_READBACK_EN
  logic err_verify_q;
  assign err_verify = err_verify_q;
`else
  logic unused_rdata;
  assign err_verify   = 1'b0;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      instr_count <= '0;
`ifdef ENC_READBACK_EN
      err_verify_q <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr        <= base_addr;
            instr_count <= '0;
            err_illegal <= 1'b0;
`ifdef ENC_READBACK_EN
            err_verify_q <= 1'b0;
`endif
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            last_q    <= in_last;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= enc_word;
            if (enc_illegal)
              err_illegal <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr        <= addr + 1'b1;
          instr_count <= cnt_inc;
`ifdef ENC_READBACK_EN
          state       <= S_RDBK;
`else
          if (last_q || (cnt_inc == MAX_CNT)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_ACCEPT;
          end
`endif
        end
`ifdef ENC_READBACK_EN
        // mem_addr still holds the written address, so the sync read lands in CHECK.
        S_RDBK: state <= S_CHECK;
        S_CHECK: begin
          if (mem_rdata != mem_wdata)
            err_verify_q <= 1'b1;
          if (last_q || (instr_count == MAX_CNT)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_ACCEPT;
          end
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed + randomized bench for instr_encoder_loader (MAX_INSTRS=4) with a memory model
// and an encoding reference model; build with ENC_READBACK_EN to exercise readback verify.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int MAXI   = 4;
`ifdef ENC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic              use_imm = 1'b0;
  logic [3:0]        op = '0;
  logic [3:0]        rdest = '0;
  logic [3:0]        rsrc = '0;
  logic [7:0]        imm8 = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;
  logic              busy;
  logic              done;
  logic              err_illegal;
  logic              err_verify;
  logic [ADDR_W:0]   instr_count;
  logic [2:0]        dbg_state;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_INSTRS(MAXI)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .use_imm(use_imm), .op(op), .rdest(rdest), .rsrc(rsrc), .imm8(imm8),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_verify(err_verify),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model (sync write, 1-cycle sync read) ----------------
  logic [15:0] mem [0:1023];
  bit          corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr] ^ (corrupt ? 16'h0010 : 16'h0000);
  end

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  int          m_addr, m_count;
  bit          m_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_word(bit ui, int o, int rd, int rs, int im);
    int w;
    if (ui && o == 0) w = 0;
    else if (ui)      w = o * 4096 + rd * 256 + im;
    else              w = rd * 256 + o * 16 + rs;
    return w[15:0];
  endfunction

  // Every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (reset && mem_we === 1'b1) begin
      logic [31:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected write", {6'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write addr", 32'(mem_addr), {16'd0, e[31:16]});
        check("write data", 32'(mem_wdata), {16'd0, e[15:0]});
        check("in_ready low in WRITE", 32'(in_ready), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base[ADDR_W-1:0];
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom_range(0, 1023);
    m_addr = base; m_count = 0; m_ill = 1'b0;
    check("busy after start", 32'(busy), 32'd1);
    check("count cleared", 32'(instr_count), 32'd0);
    check("err_illegal cleared", 32'(err_illegal), 32'd0);
  endtask

  task automatic send(input bit ui, input int o, input int rd, input int rs, input int im,
                      input bit last);
    int n = 0;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    use_imm = ui; op = o[3:0]; rdest = rd[3:0]; rsrc = rs[3:0]; imm8 = im[7:0];
    in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("in_ready wait", 32'(in_ready), 32'd1);
    exp_q.push_back({6'd0, m_addr[ADDR_W-1:0], model_word(ui, o, rd, rs, im)});
    m_addr = (m_addr + 1) % 1024;
    m_count++;
    if (ui && o == 0) m_ill = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_rand(input bit last);
    send(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 15), $urandom_range(0, 255), last);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check($sformatf("%s done", tag), 32'(done), 32'd1);
    check($sformatf("%s count", tag), 32'(instr_count), 32'(m_count));
    check($sformatf("%s err_illegal", tag), 32'(err_illegal), 32'(m_ill));
    check($sformatf("%s err_verify", tag), 32'(err_verify), 32'(RB && corrupt));
    @(negedge clk);
    check($sformatf("%s done one cycle", tag), 32'(done), 32'd0);
    check($sformatf("%s idle", tag), 32'(busy), 32'd0);
    check($sformatf("%s holds count", tag), 32'(instr_count), 32'(m_count));
    check($sformatf("%s queue drained", tag), 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    // reset
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst errs", {30'd0, err_illegal, err_verify}, 32'd0);
    check("rst count", 32'(instr_count), 32'd0);
    check("rst mem_addr/wdata", {6'd0, mem_addr, mem_wdata}, 32'd0);
    reset = 1'b1;

    // RR form, single instruction
    do_start(16'h010);
    send(1'b0, 5, 3, 4, 0, 1'b1);
    wait_done("rr");

    // immediate form
    do_start($urandom_range(0, 1000));
    send(1'b1, 5, 2, 0, 8'h7F, 1'b1);
    wait_done("imm");

    // illegal immediate with zero opcode, sticky until next start
    do_start($urandom_range(0, 1000));
    send(1'b1, 0, 7, 0, 8'hAB, 1'b0);
    send(1'b0, 9, 1, 2, 0, 1'b1);
    wait_done("illegal");
    repeat (2) @(negedge clk);
    check("illegal sticky", 32'(err_illegal), 32'd1);
    do_start(0);
    send(1'b0, 11, 4, 5, 0, 1'b1);
    wait_done("after illegal");

    // address wrap
    do_start(1023);
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done("wrap");

    // session cap without in_last; a start pulse mid-session is ignored
    do_start($urandom_range(0, 1023));
    send_rand(1'b0);
    send_rand(1'b0);
    @(negedge clk);
    start = 1'b1; base_addr = 10'h155;
    @(negedge clk);
    start = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    wait_done("max");

    // random sessions
    for (int s = 0; s < 6; s++) begin
      int len = $urandom_range(1, 4);
      do_start($urandom_range(0, 1023));
      for (int k = 1; k <= len; k++) send_rand(k == len && len < 4);
      wait_done($sformatf("rand%0d", s));
    end

    // reset while in WRITE
    do_start($urandom_range(0, 1023));
    send_rand(1'b1);
    check("in WRITE before reset", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("rst mid in_ready", 32'(in_ready), 32'd0);
    check("rst mid mem_we", 32'(mem_we), 32'd0);
    check("rst mid busy/done", {30'd0, busy, done}, 32'd0);
    check("rst mid count", 32'(instr_count), 32'd0);
    check("rst mid addr/data", {6'd0, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after reset", {29'd0, dbg_state}, 32'd0);
    check("busy after reset", 32'(busy), 32'd0);

    // readback verify: corrupted then clean memory
    corrupt = 1'b1;
    do_start($urandom_range(0, 1023));
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done("corrupt");
    corrupt = 1'b0;
    do_start($urandom_range(0, 1023));
    send_rand(1'b0);
    send_rand(1'b1);
    wait_done("clean");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
